// File: rtl/tt_um_jleugeri_ttt_demux.sv
// TTT event demux: fans each source event out over a programmable connection table into
// per-target signed token accumulators. Optional macro TTT_DEMUX_SATURATE_EN selects clamping adds.
module tt_um_jleugeri_ttt_demux #(
   parameter int NUM_PROCESSORS  = 10,
   parameter int NEW_TOKENS_BITS = 4,
   parameter int MAX_FANOUT      = 4,
   localparam int IDX_W  = $clog2(NUM_PROCESSORS),
   localparam int SLOT_W = (MAX_FANOUT > 1) ? $clog2(MAX_FANOUT) : 1
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       go_in,
   input  logic                                       done_in,
   input  logic                                       hot_in,
   input  logic [IDX_W-1:0]                           idx_in,
   input  logic                                       t_start_in,
   input  logic                                       t_stop_in,
   output logic                                       next_out,
   input  logic                                       cfg_we,
   input  logic [IDX_W-1:0]                           cfg_src,
   input  logic [SLOT_W-1:0]                          cfg_slot,
   input  logic [IDX_W-1:0]                           cfg_tgt,
   input  logic                                       cfg_valid,
   input  logic [NEW_TOKENS_BITS-1:0]                 cfg_good_w,
   input  logic [NEW_TOKENS_BITS-1:0]                 cfg_bad_w,
   output logic [NUM_PROCESSORS*NEW_TOKENS_BITS-1:0]  new_good_tokens,
   output logic [NUM_PROCESSORS*NEW_TOKENS_BITS-1:0]  new_bad_tokens,
   output logic                                       enable,
   output logic                                       busy_out
);

   localparam int N = NEW_TOKENS_BITS;
   localparam logic [IDX_W:0]    NUM_P     = (IDX_W+1)'(NUM_PROCESSORS);
   localparam logic [SLOT_W:0]   FAN_P     = (SLOT_W+1)'(MAX_FANOUT);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(MAX_FANOUT - 1);

`ifdef TTT_DEMUX_SATURATE_EN
   localparam int PW = N + 1;
   localparam logic signed [N+1:0] TOK_MAX = (N+2)'((1 << (N-1)) - 1);
   localparam logic signed [N+1:0] TOK_MIN = (N+2)'(-(1 << (N-1)));

   function automatic logic signed [N-1:0] clamp_tok(input logic signed [N+1:0] v);
      if (v > TOK_MAX)      return TOK_MAX[N-1:0];
      else if (v < TOK_MIN) return TOK_MIN[N-1:0];
      else                  return v[N-1:0];
   endfunction

   function automatic logic signed [N-1:0] add_tok(input logic signed [N-1:0] acc,
                                                   input logic signed [PW-1:0] prod);
      logic signed [N-1:0] p_c;
      p_c = clamp_tok({prod[PW-1], prod});
      return clamp_tok({{2{acc[N-1]}}, acc} + {{2{p_c[N-1]}}, p_c});
   endfunction
`else
   // Wrapping: the product's extra bit cannot affect the low N bits, so keep it N wide.
   localparam int PW = N;

   function automatic logic signed [N-1:0] add_tok(input logic signed [N-1:0] acc,
                                                   input logic signed [PW-1:0] prod);
      return acc + prod;
   endfunction
`endif

   function automatic logic signed [PW-1:0] scale_w(input logic signed [N-1:0] w, input logic neg);
      logic signed [PW-1:0] w_ext;
      w_ext = PW'(w);
      return neg ? -w_ext : w_ext;
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FANOUT, S_FLUSH} state_t;

   state_t            state_reg, state_next;
   logic [IDX_W-1:0]  src_reg, src_next;
   logic [SLOT_W-1:0] slot_reg, slot_next;
   logic              active_reg, active_next;
   logic              neg_reg, neg_next;
   logic              done_pend_reg, done_pend_next;

   logic                     tbl_valid_reg [NUM_PROCESSORS][MAX_FANOUT];
   logic [IDX_W-1:0]         tbl_tgt_reg   [NUM_PROCESSORS][MAX_FANOUT];
   logic signed [N-1:0]      tbl_good_reg  [NUM_PROCESSORS][MAX_FANOUT];
   logic signed [N-1:0]      tbl_bad_reg   [NUM_PROCESSORS][MAX_FANOUT];

   logic signed [N-1:0] good_arr [NUM_PROCESSORS];
   logic signed [N-1:0] bad_arr  [NUM_PROCESSORS];

   logic                cfg_ok, idx_ok, upd;
   logic [IDX_W-1:0]    cur_tgt;
   logic signed [N-1:0] good_upd, bad_upd;

   assign cfg_ok = (state_reg == S_IDLE) && cfg_we &&
                   ({1'b0, cfg_src} < NUM_P) && ({1'b0, cfg_tgt} < NUM_P) &&
                   ({1'b0, cfg_slot} < FAN_P);
   assign idx_ok = ({1'b0, idx_in} < NUM_P);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_PROCESSORS; i++)
            for (int j = 0; j < MAX_FANOUT; j++)
               tbl_valid_reg[i][j] <= 1'b0;
      end else if (cfg_ok) begin
         tbl_valid_reg[cfg_src][cfg_slot] <= cfg_valid;
      end
   end

   // Payload fields are only meaningful behind a valid bit, so they need no reset.
   always_ff @(posedge clk) begin
      if (cfg_ok) begin
         tbl_tgt_reg[cfg_src][cfg_slot]  <= cfg_tgt;
         tbl_good_reg[cfg_src][cfg_slot] <= cfg_good_w;
         tbl_bad_reg[cfg_src][cfg_slot]  <= cfg_bad_w;
      end
   end

   always_comb begin
      cur_tgt  = tbl_tgt_reg[src_reg][slot_reg];
      upd      = (state_reg == S_FANOUT) && active_reg && tbl_valid_reg[src_reg][slot_reg];
      good_upd = add_tok(good_arr[cur_tgt], scale_w(tbl_good_reg[src_reg][slot_reg], neg_reg));
      bad_upd  = add_tok(bad_arr[cur_tgt],  scale_w(tbl_bad_reg[src_reg][slot_reg],  neg_reg));
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PROCESSORS; gi++) begin : g_acc
         logic signed [N-1:0] good_reg, bad_reg;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               good_reg <= '0;
               bad_reg  <= '0;
            end else if (go_in) begin
               good_reg <= '0;
               bad_reg  <= '0;
            end else if (upd && (cur_tgt == IDX_W'(gi))) begin
               good_reg <= good_upd;
               bad_reg  <= bad_upd;
            end
         end

         assign good_arr[gi] = good_reg;
         assign bad_arr[gi]  = bad_reg;
         assign new_good_tokens[gi*N +: N] = good_reg;
         assign new_bad_tokens[gi*N +: N]  = bad_reg;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         src_reg       <= '0;
         slot_reg      <= '0;
         active_reg    <= 1'b0;
         neg_reg       <= 1'b0;
         done_pend_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         src_reg       <= src_next;
         slot_reg      <= slot_next;
         active_reg    <= active_next;
         neg_reg       <= neg_next;
         done_pend_reg <= done_pend_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      src_next       = src_reg;
      slot_next      = slot_reg;
      active_next    = active_reg;
      neg_next       = neg_reg;
      done_pend_next = done_pend_reg;
      next_out       = 1'b0;
      enable         = 1'b0;
      busy_out       = (state_reg != S_IDLE);

      case (state_reg)
         S_IDLE: begin
            if (go_in) begin
               state_next     = S_WAIT;
               done_pend_next = 1'b0;
            end
         end
         S_WAIT: begin
            if (go_in) begin
               done_pend_next = 1'b0;
            end else if (hot_in) begin
               // An out-of-range source or a zero sign is acked after a single cycle.
               state_next     = S_FANOUT;
               src_next       = idx_ok ? idx_in : '0;
               slot_next      = '0;
               active_next    = (t_start_in ^ t_stop_in) && idx_ok;
               neg_next       = t_stop_in;
               done_pend_next = done_in;
            end else if (done_in) begin
               state_next = S_FLUSH;
            end
         end
         S_FANOUT: begin
            if (go_in) begin
               state_next     = S_WAIT;
               done_pend_next = 1'b0;
            end else begin
               if (done_in) done_pend_next = 1'b1;
               if (!active_reg || (slot_reg == SLOT_LAST)) begin
                  next_out       = 1'b1;
                  state_next     = (done_pend_reg || done_in) ? S_FLUSH : S_WAIT;
                  done_pend_next = 1'b0;
               end else begin
                  slot_next = slot_reg + 1'b1;
               end
            end
         end
         S_FLUSH: begin
            if (go_in) begin
               state_next = S_WAIT;
            end else begin
               enable     = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_demux.sv
// Randomized scoreboard bench for tt_um_jleugeri_ttt_demux against an arithmetic token model;
// honours TTT_DEMUX_SATURATE_EN the same way the design does.
module tb_tt_um_jleugeri_ttt_demux;
   localparam int NP = 10;
   localparam int NB = 4;
   localparam int MF = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic go_in = 0, done_in = 0, hot_in = 0, t_start_in = 0, t_stop_in = 0;
   logic [3:0] idx_in = '0;
   logic next_out, enable, busy_out;
   logic cfg_we = 0, cfg_valid = 0;
   logic [3:0] cfg_src = '0, cfg_tgt = '0;
   logic [1:0] cfg_slot = '0;
   logic [NB-1:0] cfg_good_w = '0, cfg_bad_w = '0;
   logic [NP*NB-1:0] new_good_tokens, new_bad_tokens;

   tt_um_jleugeri_ttt_demux dut (
      .clk(clk), .reset(reset), .go_in(go_in), .done_in(done_in), .hot_in(hot_in),
      .idx_in(idx_in), .t_start_in(t_start_in), .t_stop_in(t_stop_in), .next_out(next_out),
      .cfg_we(cfg_we), .cfg_src(cfg_src), .cfg_slot(cfg_slot), .cfg_tgt(cfg_tgt),
      .cfg_valid(cfg_valid), .cfg_good_w(cfg_good_w), .cfg_bad_w(cfg_bad_w),
      .new_good_tokens(new_good_tokens), .new_bad_tokens(new_bad_tokens),
      .enable(enable), .busy_out(busy_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural model: connection table and token counters as plain integers.
   int m_good [NP];
   int m_bad  [NP];
   int t_valid [NP][MF];
   int t_tgt   [NP][MF];
   int t_g     [NP][MF];
   int t_b     [NP][MF];

   // Wrap modulo 2^NB, or clamp, into the signed NB-bit range.
   function automatic int fold(input int v);
      int lim, r;
      lim = 1 << (NB - 1);
`ifdef TTT_DEMUX_SATURATE_EN
      if (v > lim - 1) return lim - 1;
      if (v < -lim) return -lim;
      return v;
`else
      r = v & ((1 << NB) - 1);
      return (r >= lim) ? r - (1 << NB) : r;
`endif
   endfunction

   function automatic void model_clear_acc();
      for (int i = 0; i < NP; i++) begin
         m_good[i] = 0;
         m_bad[i]  = 0;
      end
   endfunction

   function automatic void model_clear_table();
      for (int i = 0; i < NP; i++)
         for (int j = 0; j < MF; j++) t_valid[i][j] = 0;
   endfunction

   function automatic void model_event(input int idx, input int st, input int sp);
      int s, t;
      s = st - sp;
      if (s == 0 || idx >= NP) return;
      for (int j = 0; j < MF; j++) begin
         if (t_valid[idx][j] != 0) begin
            t = t_tgt[idx][j];
            m_good[t] = fold(m_good[t] + fold(s * t_g[idx][j]));
            m_bad[t]  = fold(m_bad[t]  + fold(s * t_b[idx][j]));
         end
      end
   endfunction

   function automatic logic [NP*NB-1:0] pack_model(input bit bad);
      logic [NP*NB-1:0] r;
      for (int i = 0; i < NP; i++) r[i*NB +: NB] = NB'(bad ? m_bad[i] : m_good[i]);
      return r;
   endfunction

   typedef struct {
      logic [NP*NB-1:0] g;
      logic [NP*NB-1:0] b;
      int               cyc;
   } frame_t;

   int     ack_q [$];
   frame_t frm_q [$];

   // Monitor: pops expectations whenever the DUT acks an event or closes a frame.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (next_out === 1'b1) begin
            if (ack_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_next_out: got 1 expected 0 (cyc %0d)", cyc);
            end else begin
               int e;
               e = ack_q.pop_front();
               check("ack_cycle", cyc, e);
               $display("ack      cyc=%0d expected_cyc=%0d", cyc, e);
            end
         end
         if (enable === 1'b1) begin
            if (frm_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_enable: got 1 expected 0 (cyc %0d)", cyc);
            end else begin
               frame_t f;
               f = frm_q.pop_front();
               check("enable_cycle", cyc, f.cyc);
               check("frame_good", new_good_tokens, f.g);
               check("frame_bad", new_bad_tokens, f.b);
               $display("frame    cyc=%0d good=%h bad=%h", cyc, new_good_tokens, new_bad_tokens);
            end
         end
      end
   end

   task automatic cfg_write(input int src, input int slot, input int tgt, input int valid,
                            input int g, input int b, input bit in_idle);
      @(negedge clk);
      cfg_we = 1'b1;
      cfg_src = src[3:0];
      cfg_slot = slot[1:0];
      cfg_tgt = tgt[3:0];
      cfg_valid = (valid != 0);
      cfg_good_w = g[NB-1:0];
      cfg_bad_w = b[NB-1:0];
      if (in_idle && src < NP && tgt < NP && slot < MF) begin
         t_valid[src][slot] = valid;
         t_tgt[src][slot] = tgt;
         t_g[src][slot] = g;
         t_b[src][slot] = b;
      end
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic go();
      @(negedge clk);
      go_in = 1'b1;
      model_clear_acc();
      @(negedge clk);
      go_in = 1'b0;
   endtask

   task automatic send_event(input int idx, input int st, input int sp);
      int lat;
      @(negedge clk);
      hot_in = 1'b1;
      idx_in = idx[3:0];
      t_start_in = st[0];
      t_stop_in = sp[0];
      lat = (st != sp && idx < NP) ? MF : 1;
      ack_q.push_back(cyc + lat);
      model_event(idx, st, sp);
      @(negedge clk);
      hot_in = 1'b0;
      repeat (lat) @(negedge clk);
   endtask

   task automatic done_frame();
      frame_t f;
      @(negedge clk);
      done_in = 1'b1;
      f.g = pack_model(1'b0);
      f.b = pack_model(1'b1);
      f.cyc = cyc + 1;
      frm_q.push_back(f);
      @(negedge clk);
      done_in = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_next_out"}, next_out, 0);
      check({tag, "_enable"}, enable, 0);
      check({tag, "_busy"}, busy_out, 0);
      check({tag, "_good"}, new_good_tokens, 0);
      check({tag, "_bad"}, new_bad_tokens, 0);
   endtask

   initial begin
      frame_t f;
      int c0, n_ev;
      model_clear_acc();
      model_clear_table();
      repeat (3) @(negedge clk);
      #1;
      check_idle_outputs("reset");
      @(negedge clk);
      reset = 1'b0;

      // Single slot, +3/-1, one start event.
      cfg_write(2, 0, 5, 1, 3, -1, 1'b1);
      go();
      send_event(2, 1, 0);
      done_frame();
      check("t2_good5", new_good_tokens[23:20], 4'd3);
      check("t2_bad5", new_bad_tokens[23:20], 4'hF);

      // Start and stop together: one-cycle ack, nothing accumulates.
      go();
      send_event(2, 1, 1);
      done_frame();

      // Weight 7 applied three times.
      cfg_write(2, 0, 5, 1, 7, -1, 1'b1);
      go();
      repeat (3) send_event(2, 1, 0);
      done_frame();
`ifdef TTT_DEMUX_SATURATE_EN
      check("t4_good5", new_good_tokens[23:20], 4'd7);
`else
      check("t4_good5", new_good_tokens[23:20], 4'd5);
`endif

      // Table write outside IDLE is ignored.
      go();
      cfg_write(2, 0, 7, 1, 5, 5, 1'b0);
      send_event(2, 0, 1);
      done_frame();

      // go_in during FANOUT aborts: counters cleared, no ack, no enable.
      go();
      send_event(2, 1, 0);
      @(negedge clk);
      hot_in = 1'b1; idx_in = 4'd2; t_start_in = 1'b1; t_stop_in = 1'b0;
      @(negedge clk);
      hot_in = 1'b0;
      @(negedge clk);
      go_in = 1'b1;
      model_clear_acc();
      @(negedge clk);
      go_in = 1'b0;
      #1;
      check("abort_good", new_good_tokens, 0);
      check("abort_busy", busy_out, 1);
      done_frame();

      // done_in in the second FANOUT cycle: event completes, then enable.
      go();
      @(negedge clk);
      hot_in = 1'b1; idx_in = 4'd2; t_start_in = 1'b1; t_stop_in = 1'b0;
      c0 = cyc;
      ack_q.push_back(c0 + MF);
      model_event(2, 1, 0);
      @(negedge clk);
      hot_in = 1'b0;
      @(negedge clk);
      done_in = 1'b1;
      @(negedge clk);
      done_in = 1'b0;
      f.g = pack_model(1'b0);
      f.b = pack_model(1'b1);
      f.cyc = c0 + MF + 1;
      frm_q.push_back(f);
      repeat (3) @(negedge clk);

      // Reset in the middle of FANOUT, then confirm the table is gone.
      go();
      @(negedge clk);
      hot_in = 1'b1; idx_in = 4'd2; t_start_in = 1'b1; t_stop_in = 1'b0;
      @(negedge clk);
      hot_in = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_idle_outputs("midreset");
      model_clear_acc();
      model_clear_table();
      @(negedge clk);
      reset = 1'b0;
      go();
      send_event(2, 1, 0);
      done_frame();

      // Random tables and event streams, including out-of-range indices.
      for (int fr = 0; fr < 8; fr++) begin
         for (int w = 0; w < 10; w++)
            cfg_write($urandom_range(0, 11), $urandom_range(0, 3), $urandom_range(0, 11),
                      int'($urandom_range(0, 3) != 0),
                      int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8, 1'b1);
         go();
         n_ev = $urandom_range(6, 12);
         for (int e = 0; e < n_ev; e++)
            send_event($urandom_range(0, 11), $urandom_range(0, 1), $urandom_range(0, 1));
         done_frame();
      end

      repeat (5) @(negedge clk);
      check("ack_queue_drained", ack_q.size(), 0);
      check("frame_queue_drained", frm_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
